act_mon_reset_gen: RTL and testbench
====================================

ACT_MON_RESET_GEN -- requirements
Module: act_mon_reset_gen

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of monitored activity lines (legal 1..8).
REQ-002 SHALL have parameter TIMEOUT, default 1000000, activity hold time in clk_sys cycles (legal >=1).
REQ-003 SHALL have parameter RST_HOLD, default 10000000, mount-reset pulse length in cycles (0 = no pulse).
REQ-004 SHALL have parameter BLINK_DIV, default 2000000, half-period of the LED blink in cycles (legal >=1).
REQ-005 SHALL have port clk_sys  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port act_in  input  CHANNELS  monitored lines (e.g. SD MOSI/MISO), treated as synchronous.
REQ-008 SHALL have port busy_in  input  1  forces LED on (e.g. download in progress).
REQ-009 SHALL have port mount_stb  input  1  one-cycle image-mounted strobe.
REQ-010 SHALL have port mount_size_nz  input  1  mounted image size nonzero; sampled on mount_stb.
REQ-011 SHALL have port act  output  CHANNELS  per-channel activity flag.
REQ-012 SHALL have port led_n  output  1  activity LED, active-low, registered.
REQ-013 SHALL have port media_sel  output  1  latched mount_size_nz (virtual media selected).
REQ-014 SHALL have port reset_req  output  1  stretched reset request to the core.

Function
REQ-015 Each channel SHALL register a previous sample of act_in[i]; a change is any cycle where act_in[i] differs from that sample.
REQ-016 Each channel SHALL own a counter of width clog2(TIMEOUT+1): on change, load 0; else increment while below TIMEOUT; saturate at TIMEOUT.
REQ-017 act[i] SHALL equal (counter_i != TIMEOUT); after the last change act[i] stays high exactly TIMEOUT cycles, starting the cycle after the change is sampled.
REQ-018 A change while counter_i is mid-count SHALL reload 0 (retrigger); channels SHALL be fully independent.
REQ-019 any_act SHALL be OR of act[] and busy_in; led_n SHALL be registered ~any_act (one-cycle latency) unless REQ-030 applies.
REQ-020 On mount_stb, media_sel SHALL load mount_size_nz and the hold counter SHALL load RST_HOLD, effective next edge.
REQ-021 Hold counter SHALL decrement to 0 and stop; reset_req SHALL equal (hold != 0), i.e. high exactly RST_HOLD cycles after the strobe.
REQ-022 mount_stb while reset_req is high SHALL reload RST_HOLD (pulse extends) and re-sample mount_size_nz.
REQ-023 With RST_HOLD=0, mount_stb SHALL update media_sel and SHALL NOT assert reset_req.
REQ-024 Activity monitoring SHALL continue unaffected while reset_req is high.

Reset
REQ-025 While reset is high at a clock edge: previous samples load current act_in (no false change on release), channel counters load TIMEOUT, act=0.
REQ-026 Reset SHALL clear hold counter (reset_req=0 next cycle, aborting any pulse), media_sel=0, led_n=1, blink counter=0, blink phase=1.
REQ-027 mount_stb coincident with reset SHALL be ignored; reset has priority over every event.

Configuration
REQ-028 Macro ACT_MON_BLINK_EN SHALL select LED blink mode at compile time.
REQ-029 Without ACT_MON_BLINK_EN: led_n follows REQ-019 (solid on while active); no blink counter is built.
REQ-030 With ACT_MON_BLINK_EN: free-running counter wraps every BLINK_DIV cycles and toggles phase; led_n = ~((|act & phase) | busy_in), registered; busy_in stays solid on.

Verification (CHANNELS=2, TIMEOUT=8, RST_HOLD=5, BLINK_DIV=4)
REQ-031 Release reset with act_in=2'b11 held constant -> act=00, led_n=1 indefinitely.
REQ-032 Toggle act_in[0] once at cycle 10 -> act[0]=1 cycles 11..18, 0 at 19; led_n=0 cycles 12..19; act[1]=0 throughout.
REQ-033 Toggle act_in[1] at cycles 10 and 15 -> act[1]=1 cycles 11..23 (retrigger), 0 at 24.
REQ-034 mount_stb with mount_size_nz=1 at cycle 20 -> media_sel=1 from 21, reset_req=1 cycles 21..25; second strobe at 23 -> reset_req high through 28.
REQ-035 Assert reset at cycle 23 mid-pulse -> reset_req=0, media_sel=0 at 24; strobe at 23 ignored.
REQ-036 With ACT_MON_BLINK_EN, continuous toggling on act_in[0] -> led_n alternates 4 cycles low/4 high; busy_in=1 -> led_n=0 solid.

Source files
------------

// File: rtl/act_mon_reset_gen.sv
// act_mon_reset_gen
//   Per-channel activity monitor with retriggerable hold timers, an activity
//   LED driver and a stretched reset request raised when an image is mounted.
//   Compile-time option: define ACT_MON_BLINK_EN to make the LED blink while
//   channel activity is present (busy_in still lights it solid).
//   All logic runs on the rising edge of clk_sys; reset is synchronous,
//   active-high and has priority over every other event.

module act_mon_reset_gen #(
   parameter int CHANNELS  = 2,
   parameter int TIMEOUT   = 1000000,
   parameter int RST_HOLD  = 10000000,
   parameter int BLINK_DIV = 2000000
) (
   input  logic                clk_sys,
   input  logic                reset,
   input  logic [CHANNELS-1:0] act_in,
   input  logic                busy_in,
   input  logic                mount_stb,
   input  logic                mount_size_nz,
   output logic [CHANNELS-1:0] act,
   output logic                led_n,
   output logic                media_sel,
   output logic                reset_req
);

   // Activity counter width holds 0..TIMEOUT inclusive.
   localparam int            TW   = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

   // Hold counter keeps at least one bit so RST_HOLD=0 still elaborates;
   // with RST_HOLD=0 it simply reloads 0 and reset_req never rises.
   localparam int            HW   = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
   localparam logic [HW-1:0] HMAX = HW'(RST_HOLD);

   // Reject illegal parameterisations at elaboration time.
   if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
      $error("act_mon_reset_gen: CHANNELS must be 1..8");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("act_mon_reset_gen: TIMEOUT must be >= 1");
   end
   if (RST_HOLD < 0) begin : g_bad_rst_hold
      $error("act_mon_reset_gen: RST_HOLD must be >= 0");
   end
   if (BLINK_DIV < 1) begin : g_bad_blink_div
      $error("act_mon_reset_gen: BLINK_DIV must be >= 1");
   end

   // ------------------------------------------------------------------
   // Per-channel activity timers
   // ------------------------------------------------------------------
   logic [CHANNELS-1:0] w_chg;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      logic          r_prev;
      logic [TW-1:0] r_cnt;

      assign w_chg[g] = act_in[g] ^ r_prev;
      assign act[g]   = (r_cnt != TMAX);

      // Edge detector plus retriggerable saturating timer. Reset samples the
      // live input so its release never looks like a change.
      always_ff @(posedge clk_sys) begin
         r_prev <= act_in[g];
         if (reset) begin
            r_cnt <= TMAX;
         end else if (w_chg[g]) begin
            r_cnt <= '0;
         end else if (r_cnt < TMAX) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Mount handling: media select latch and stretched reset request
   // ------------------------------------------------------------------
   logic [HW-1:0] r_hold;
   logic          r_media_sel;

   // A strobe reloads the full pulse (extending a running one) and
   // resamples the size flag; otherwise the hold counter drains to 0.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_hold      <= '0;
         r_media_sel <= 1'b0;
      end else if (mount_stb) begin
         r_hold      <= HMAX;
         r_media_sel <= mount_size_nz;
      end else if (r_hold != '0) begin
         r_hold      <= r_hold - 1'b1;
      end
   end

   assign media_sel = r_media_sel;
   assign reset_req = (r_hold != '0);

   // ------------------------------------------------------------------
   // Activity LED
   // ------------------------------------------------------------------
   logic w_chan_act;
   logic w_led_on;
   logic r_led_n;

   assign w_chan_act = |act;

`ifdef ACT_MON_BLINK_EN
   localparam int            BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

   logic [BW-1:0] r_blink_cnt;
   logic          r_phase;

   // Free-running divider: every BLINK_DIV cycles the blink phase flips.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b1;
      end else if (r_blink_cnt == BMAX) begin
         r_blink_cnt <= '0;
         r_phase     <= ~r_phase;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   // Channel activity blinks; busy_in overrides to solid on.
   assign w_led_on = (w_chan_act & r_phase) | busy_in;
`else
   // Solid on while any channel is active or busy_in is asserted.
   assign w_led_on = w_chan_act | busy_in;
`endif

   // Registered active-low LED drive.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_led_n <= 1'b1;
      end else begin
         r_led_n <= ~w_led_on;
      end
   end

   assign led_n = r_led_n;

endmodule

// File: tb/tb_act_mon_reset_gen.sv
// Scoreboard bench for act_mon_reset_gen (CHANNELS=2, TIMEOUT=8,
// RST_HOLD=5, BLINK_DIV=4). Expected values are queued per cycle as
// stimulus is planned; a monitor checks them on the falling edge.

module tb_act_mon_reset_gen;

   logic       clk_sys = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] act_in = 2'b00;
   logic       busy_in = 1'b0;
   logic       mount_stb = 1'b0;
   logic       mount_size_nz = 1'b0;
   logic [1:0] act;
   logic       led_n;
   logic       media_sel;
   logic       reset_req;

   act_mon_reset_gen #(
      .CHANNELS (2),
      .TIMEOUT  (8),
      .RST_HOLD (5),
      .BLINK_DIV(4)
   ) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .act_in       (act_in),
      .busy_in      (busy_in),
      .mount_stb    (mount_stb),
      .mount_size_nz(mount_size_nz),
      .act          (act),
      .led_n        (led_n),
      .media_sel    (media_sel),
      .reset_req    (reset_req)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      int         cyc;
      int         kind;   // 0 act, 1 led_n, 2 media_sel, 3 reset_req
      logic [1:0] exp;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   base = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   initial forever begin
      @(posedge clk_sys);
      cyc = cyc + 1;
   end

   function automatic logic [1:0] observe(input int kind);
      case (kind)
         0:       return act;
         1:       return {1'b0, led_n};
         2:       return {1'b0, media_sel};
         default: return {1'b0, reset_req};
      endcase
   endfunction

   function automatic string kname(input int kind);
      case (kind)
         0:       return "act";
         1:       return "led_n";
         2:       return "media_sel";
         default: return "reset_req";
      endcase
   endfunction

   // Monitor: pop every expectation due this cycle and compare.
   initial forever begin
      exp_t       e;
      logic [1:0] got;
      @(negedge clk_sys);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e   = q.pop_front();
         got = observe(e.kind);
         n_chk++;
         if (e.cyc < cyc)
            $display("FAIL %s stale expectation cyc=%0d now=%0d", kname(e.kind), e.cyc, cyc);
         else if (got === e.exp)
            n_pass++;
         else
            $display("FAIL %s rel_cyc=%0d got=%b want=%b", kname(e.kind), e.cyc - base, got, e.exp);
      end
   end

   task automatic expect_cyc(input int k, input logic [1:0] a, input logic l,
                             input logic m, input logic r);
      exp_t e;
      e.cyc = base + k;
      e.kind = 0; e.exp = a;         q.push_back(e);
      e.kind = 1; e.exp = {1'b0, l}; q.push_back(e);
      e.kind = 2; e.exp = {1'b0, m}; q.push_back(e);
      e.kind = 3; e.exp = {1'b0, r}; q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   // Three reset cycles with act_in held at a; cycle 0 of the following
   // scenario is the first cycle with reset low.
   task automatic do_reset(input logic [1:0] a);
      int c;
      c = cyc;
      reset = 1'b1; act_in = a; busy_in = 1'b0;
      mount_stb = 1'b0; mount_size_nz = 1'b0;
      base = c;
      expect_cyc(1, 2'b00, 1'b1, 1'b0, 1'b0);
      expect_cyc(2, 2'b00, 1'b1, 1'b0, 1'b0);
      wait_cyc(c + 3);
      reset = 1'b0;
      base = cyc;
   endtask

   function automatic logic ph(input int j);
      return ((j / 4) % 2) == 0;
   endfunction

   initial begin
      // ---- A: quiet release, single toggle on ch0, double mount strobe
      do_reset(2'b11);
      for (int k = 0; k < 30; k++)
         expect_cyc(k, {1'b0, (k >= 11 && k <= 18)}, !(k >= 12 && k <= 19),
                    (k >= 21), (k >= 21 && k <= 28));
      wait_cyc(base + 10); act_in = 2'b10;
      wait_cyc(base + 20); mount_stb = 1'b1; mount_size_nz = 1'b1;
      wait_cyc(base + 21); mount_stb = 1'b0; mount_size_nz = 1'b0;
      wait_cyc(base + 23); mount_stb = 1'b1; mount_size_nz = 1'b1;
      wait_cyc(base + 24); mount_stb = 1'b0;
      wait_cyc(base + 30);

      // ---- B: retrigger on ch1, empty-image mount, busy override
      do_reset(2'b11);
      for (int k = 0; k < 35; k++)
         expect_cyc(k, {(k >= 11 && k <= 23), 1'b0},
                    !((k >= 12 && k <= 24) || (k >= 31 && k <= 32)),
                    1'b0, (k >= 21 && k <= 25));
      wait_cyc(base + 10); act_in = 2'b01;
      wait_cyc(base + 15); act_in = 2'b11;
      wait_cyc(base + 20); mount_stb = 1'b1; mount_size_nz = 1'b0;
      wait_cyc(base + 21); mount_stb = 1'b0;
      wait_cyc(base + 30); busy_in = 1'b1;
      wait_cyc(base + 32); busy_in = 1'b0;
      wait_cyc(base + 35);

      // ---- C: reset mid-pulse with a coincident strobe
      do_reset(2'b00);
      for (int k = 0; k < 28; k++)
         expect_cyc(k, 2'b00, 1'b1, (k >= 21 && k <= 23), (k >= 21 && k <= 23));
      wait_cyc(base + 20); mount_stb = 1'b1; mount_size_nz = 1'b1;
      wait_cyc(base + 21); mount_stb = 1'b0; mount_size_nz = 1'b0;
      wait_cyc(base + 23); reset = 1'b1; mount_stb = 1'b1; mount_size_nz = 1'b1;
      wait_cyc(base + 24); reset = 1'b0; mount_stb = 1'b0; mount_size_nz = 1'b0;
      wait_cyc(base + 28);

      // ---- D: continuous toggling on ch0, then busy_in
      do_reset(2'b00);
      for (int k = 0; k < 61; k++) begin
         logic a_prev, b_prev, on;
         a_prev = (k - 1 >= 11 && k - 1 <= 47);
         b_prev = (k - 1 >= 50 && k - 1 <= 57);
`ifdef ACT_MON_BLINK_EN
         on = (a_prev && ph(k - 1)) || b_prev;
`else
         on = a_prev || b_prev;
`endif
         expect_cyc(k, {1'b0, (k >= 11 && k <= 47)}, (k == 0) ? 1'b1 : !on, 1'b0, 1'b0);
      end
      for (int j = 10; j < 40; j++) begin
         wait_cyc(base + j);
         act_in[0] = ~act_in[0];
      end
      wait_cyc(base + 50); busy_in = 1'b1;
      wait_cyc(base + 58); busy_in = 1'b0;
      wait_cyc(base + 61);

      // Drain with a bounded wait.
      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk_sys);
      @(negedge clk_sys);
      if (q.size() > 0) begin
         $display("FAIL drain %0d expectations never checked", q.size());
         n_chk = n_chk + q.size();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
